// File: rtl/coo_aggregation_unit.sv
// COO edge-list aggregation: accumulates FM x WM product rows into a per-node buffer,
// giving AGG = A * (FM * WM) for the symmetric adjacency A described by the COO list.
module coo_aggregation_unit #(
   parameter int FEATURE_ROWS       = 6,
   parameter int WEIGHT_COLS        = 3,
   parameter int NUM_EDGES          = 6,
   parameter int DOT_PROD_WIDTH     = 16,
   parameter int NODE_WIDTH         = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1,
   parameter int COUNTER_EDGE_WIDTH = (NUM_EDGES > 1) ? $clog2(NUM_EDGES) : 1
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  start,
   output logic [COUNTER_EDGE_WIDTH-1:0]         coo_address,
   output logic                                  enable_read_coo,
   input  logic [2*NODE_WIDTH-1:0]               coo_in,
   output logic [NODE_WIDTH-1:0]                 read_fm_wm_addr,
   output logic                                  enable_read_fm_wm,
   input  logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0] fm_wm_row_in,
   input  logic [NODE_WIDTH-1:0]                 agg_read_addr,
   output logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0] agg_row_out,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  coo_error
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_CLEAR     = 3'd1;
   localparam logic [2:0] S_FETCH_COO = 3'd2;
   localparam logic [2:0] S_LATCH_COO = 3'd3;
   localparam logic [2:0] S_FETCH_B   = 3'd4;
   localparam logic [2:0] S_ACC_A     = 3'd5;
   localparam logic [2:0] S_ACC_B     = 3'd6;
   localparam logic [2:0] S_DONE      = 3'd7;

   localparam int NW1 = NODE_WIDTH + 1;
   localparam logic [NW1-1:0] ROWS_C = NW1'(FEATURE_ROWS);
   localparam logic [COUNTER_EDGE_WIDTH-1:0] LAST_EDGE = COUNTER_EDGE_WIDTH'(NUM_EDGES - 1);

   logic [2:0]                    state_q, state_d;
   logic [COUNTER_EDGE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
   logic [NODE_WIDTH-1:0]         node_a_q, node_a_d;
   logic [NODE_WIDTH-1:0]         node_b_q, node_b_d;
   logic                          coo_error_q, coo_error_d;
   logic [DOT_PROD_WIDTH-1:0]     agg_q [FEATURE_ROWS][WEIGHT_COLS];
   logic [DOT_PROD_WIDTH-1:0]     agg_d [FEATURE_ROWS][WEIGHT_COLS];

   logic [NODE_WIDTH-1:0] coo_a, coo_b;
   logic                  self_loop;
   logic                  next_edge;

   assign coo_a     = coo_in[NODE_WIDTH-1:0];
   assign coo_b     = coo_in[2*NODE_WIDTH-1:NODE_WIDTH];
   assign self_loop = (node_a_q == node_b_q);

   always_comb begin
      state_d     = state_q;
      edge_cnt_d  = edge_cnt_q;
      node_a_d    = node_a_q;
      node_b_d    = node_b_q;
      coo_error_d = coo_error_q;
      agg_d       = agg_q;
      next_edge   = 1'b0;
      case (state_q)
         S_IDLE: if (start) state_d = S_CLEAR;
         S_CLEAR: begin
            for (int r = 0; r < FEATURE_ROWS; r++)
               for (int c = 0; c < WEIGHT_COLS; c++)
                  agg_d[r][c] = '0;
            edge_cnt_d  = '0;
            coo_error_d = 1'b0;
            state_d     = S_FETCH_COO;
         end
         S_FETCH_COO: state_d = S_LATCH_COO;
         S_LATCH_COO: begin
            node_a_d = coo_a;
            node_b_d = coo_b;
            if (({1'b0, coo_a} >= ROWS_C) || ({1'b0, coo_b} >= ROWS_C)) begin
               coo_error_d = 1'b1;
               next_edge   = 1'b1;
            end else begin
               state_d = S_FETCH_B;
            end
         end
         S_FETCH_B: state_d = S_ACC_A;
         S_ACC_A: begin
            // Row of node_b lands in node_a's accumulator; the reverse direction follows in ACC_B
            for (int r = 0; r < FEATURE_ROWS; r++)
               if (node_a_q == NODE_WIDTH'(r))
                  for (int c = 0; c < WEIGHT_COLS; c++)
                     agg_d[r][c] = agg_q[r][c] + fm_wm_row_in[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH];
            if (self_loop) next_edge = 1'b1;
            else           state_d   = S_ACC_B;
         end
         S_ACC_B: begin
            for (int r = 0; r < FEATURE_ROWS; r++)
               if (node_b_q == NODE_WIDTH'(r))
                  for (int c = 0; c < WEIGHT_COLS; c++)
                     agg_d[r][c] = agg_q[r][c] + fm_wm_row_in[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH];
            next_edge = 1'b1;
         end
         S_DONE: if (start) state_d = S_CLEAR;
         default: state_d = S_IDLE;
      endcase
      if (next_edge) begin
         if (edge_cnt_q == LAST_EDGE) begin
            state_d = S_DONE;
         end else begin
            edge_cnt_d = edge_cnt_q + 1'b1;
            state_d    = S_FETCH_COO;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         edge_cnt_q  <= '0;
         node_a_q    <= '0;
         node_b_q    <= '0;
         coo_error_q <= 1'b0;
         for (int r = 0; r < FEATURE_ROWS; r++)
            for (int c = 0; c < WEIGHT_COLS; c++)
               agg_q[r][c] <= '0;
      end else begin
         state_q     <= state_d;
         edge_cnt_q  <= edge_cnt_d;
         node_a_q    <= node_a_d;
         node_b_q    <= node_b_d;
         coo_error_q <= coo_error_d;
         agg_q       <= agg_d;
      end
   end

   // Memory-side strobes decode straight from state so they fall to 0 the cycle after reset
   always_comb begin
      enable_read_coo   = (state_q == S_FETCH_COO);
      coo_address       = enable_read_coo ? edge_cnt_q : '0;
      enable_read_fm_wm = 1'b0;
      read_fm_wm_addr   = '0;
      if (state_q == S_FETCH_B) begin
         enable_read_fm_wm = 1'b1;
         read_fm_wm_addr   = node_b_q;
      end else if ((state_q == S_ACC_A) && !self_loop) begin
         enable_read_fm_wm = 1'b1;
         read_fm_wm_addr   = node_a_q;
      end
   end

   assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done      = (state_q == S_DONE);
   assign coo_error = coo_error_q;

   always_comb begin
      agg_row_out = '0;
      for (int r = 0; r < FEATURE_ROWS; r++)
         if ({1'b0, agg_read_addr} == NW1'(r))
            for (int c = 0; c < WEIGHT_COLS; c++)
               agg_row_out[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH] = agg_q[r][c];
   end

endmodule

// File: tb/tb_coo_aggregation_unit.sv
// Directed bench for coo_aggregation_unit: default 6-edge instance plus a 1-edge instance.
module tb_coo_aggregation_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  coo_address;
   logic        en_coo;
   logic [5:0]  coo_in = '0;
   logic [2:0]  fm_addr;
   logic        en_fm;
   logic [47:0] fm_in = '0;
   logic [2:0]  agg_addr = '0;
   logic [47:0] agg_out;
   logic        busy, done, coo_error;

   logic        start1 = 1'b0;
   logic [0:0]  coo_address1;
   logic        en_coo1;
   logic [5:0]  coo_in1 = '0;
   logic [2:0]  fm_addr1;
   logic        en_fm1;
   logic [47:0] fm_in1 = '0;
   logic [2:0]  agg_addr1 = '0;
   logic [47:0] agg_out1;
   logic        busy1, done1, coo_error1;

   logic [5:0]  coo_mem  [8];
   logic [47:0] fm_mem   [8];
   logic [5:0]  coo_mem1 [2];
   logic [47:0] fm_mem1  [8];

   int checks = 0;
   int errors = 0;

   coo_aggregation_unit u_dut (
      .clk(clk), .reset(reset), .start(start),
      .coo_address(coo_address), .enable_read_coo(en_coo), .coo_in(coo_in),
      .read_fm_wm_addr(fm_addr), .enable_read_fm_wm(en_fm), .fm_wm_row_in(fm_in),
      .agg_read_addr(agg_addr), .agg_row_out(agg_out),
      .busy(busy), .done(done), .coo_error(coo_error)
   );

   coo_aggregation_unit #(.NUM_EDGES(1)) u_one (
      .clk(clk), .reset(reset), .start(start1),
      .coo_address(coo_address1), .enable_read_coo(en_coo1), .coo_in(coo_in1),
      .read_fm_wm_addr(fm_addr1), .enable_read_fm_wm(en_fm1), .fm_wm_row_in(fm_in1),
      .agg_read_addr(agg_addr1), .agg_row_out(agg_out1),
      .busy(busy1), .done(done1), .coo_error(coo_error1)
   );

   always @(posedge clk) begin
      if (en_coo)  coo_in  <= coo_mem[coo_address];
      if (en_fm)   fm_in   <= fm_mem[fm_addr];
      if (en_coo1) coo_in1 <= coo_mem1[coo_address1];
      if (en_fm1)  fm_in1  <= fm_mem1[fm_addr1];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [47:0] pk(input int e0, input int e1, input int e2);
      logic [15:0] a, b, c;
      a = e0[15:0]; b = e1[15:0]; c = e2[15:0];
      return {c, b, a};
   endfunction

   function automatic logic [5:0] edge_e(input int a, input int b);
      logic [2:0] na, nb;
      na = a[2:0]; nb = b[2:0];
      return {nb, na};
   endfunction

   task automatic load_ring;
      for (int i = 0; i < 6; i++) begin
         fm_mem[i]  = pk(i, i + 1, i + 2);
         coo_mem[i] = edge_e(i, (i + 1) % 6);
      end
      fm_mem[6] = '0; fm_mem[7] = '0;
   endtask

   // Pulses start (optionally again at cycle mid_pulse) and counts cycles from CLEAR entry to done
   task automatic run_main(input int mid_pulse, output int n, output bit busy_ok);
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      busy_ok = 1'b1;
      while (!done && n < 100) begin
         if (!busy) busy_ok = 1'b0;
         start = (n == mid_pulse);
         tick();
         n++;
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) tick();
      agg_addr = 3'd0;
      #1;
      checks++; if (coo_address !== 3'd0) begin errors++; $display("FAIL rst_coo_address got %h want 0", coo_address); end
      checks++; if (en_coo !== 1'b0)      begin errors++; $display("FAIL rst_en_coo got %b want 0", en_coo); end
      checks++; if (fm_addr !== 3'd0)     begin errors++; $display("FAIL rst_fm_addr got %h want 0", fm_addr); end
      checks++; if (en_fm !== 1'b0)       begin errors++; $display("FAIL rst_en_fm got %b want 0", en_fm); end
      checks++; if ({busy, done, coo_error} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {busy, done, coo_error}); end
      checks++; if (agg_out !== 48'd0)    begin errors++; $display("FAIL rst_agg got %h want 0", agg_out); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_edge;
      int n;
      logic [47:0] exp [6];
      exp = '{pk(4,5,6), 48'd0, pk(1,2,3), 48'd0, 48'd0, 48'd0};
      for (int i = 0; i < 8; i++) fm_mem1[i] = '0;
      fm_mem1[0] = pk(1, 2, 3);
      fm_mem1[2] = pk(4, 5, 6);
      coo_mem1[0] = edge_e(0, 2);
      coo_mem1[1] = '0;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      n = 0;
      while (!done1 && n < 100) begin tick(); n++; end
      checks++; if (n !== 6) begin errors++; $display("FAIL single_latency got %0d want 6", n); end
      for (int r = 0; r < 6; r++) begin
         agg_addr1 = r[2:0]; #1;
         checks++; if (agg_out1 !== exp[r]) begin errors++; $display("FAIL single_agg%0d got %h want %h", r, agg_out1, exp[r]); end
      end
   endtask

   task automatic test_ring;
      int n; bit bok;
      logic [47:0] exp [8];
      exp = '{pk(6,8,10), pk(2,4,6), pk(4,6,8), pk(6,8,10), pk(8,10,12), pk(4,6,8), 48'd0, 48'd0};
      load_ring();
      run_main(-1, n, bok);
      checks++; if (n !== 31) begin errors++; $display("FAIL ring_latency got %0d want 31", n); end
      checks++; if (bok !== 1'b1) begin errors++; $display("FAIL ring_busy got %b want 1", bok); end
      checks++; if (coo_error !== 1'b0) begin errors++; $display("FAIL ring_err got %b want 0", coo_error); end
      for (int r = 0; r < 8; r++) begin
         agg_addr = r[2:0]; #1;
         checks++; if (agg_out !== exp[r]) begin errors++; $display("FAIL ring_agg%0d got %h want %h", r, agg_out, exp[r]); end
      end
   endtask

   task automatic test_self_loop;
      int n; bit bok;
      load_ring();
      fm_mem[3]  = pk(7, 7, 7);
      coo_mem[0] = edge_e(3, 3);
      coo_mem[1] = edge_e(0, 1); coo_mem[2] = edge_e(1, 2); coo_mem[3] = edge_e(2, 3);
      coo_mem[4] = edge_e(3, 4); coo_mem[5] = edge_e(4, 5);
      run_main(-1, n, bok);
      checks++; if (n !== 30) begin errors++; $display("FAIL self_latency got %0d want 30", n); end
      agg_addr = 3'd3; #1;
      checks++; if (agg_out !== pk(13, 15, 17)) begin errors++; $display("FAIL self_agg3 got %h want %h", agg_out, pk(13, 15, 17)); end
      agg_addr = 3'd4; #1;
      checks++; if (agg_out !== pk(12, 13, 14)) begin errors++; $display("FAIL self_agg4 got %h want %h", agg_out, pk(12, 13, 14)); end
   endtask

   task automatic test_invalid_edge;
      int n; bit bok;
      load_ring();
      coo_mem[0] = edge_e(6, 1);
      coo_mem[1] = edge_e(0, 1); coo_mem[2] = edge_e(1, 2); coo_mem[3] = edge_e(2, 3);
      coo_mem[4] = edge_e(3, 4); coo_mem[5] = edge_e(4, 5);
      run_main(-1, n, bok);
      checks++; if (n !== 28) begin errors++; $display("FAIL inv_latency got %0d want 28", n); end
      checks++; if (coo_error !== 1'b1) begin errors++; $display("FAIL inv_err got %b want 1", coo_error); end
      agg_addr = 3'd1; #1;
      checks++; if (agg_out !== pk(2, 4, 6)) begin errors++; $display("FAIL inv_agg1 got %h want %h", agg_out, pk(2, 4, 6)); end
      agg_addr = 3'd0; #1;
      checks++; if (agg_out !== pk(1, 2, 3)) begin errors++; $display("FAIL inv_agg0 got %h want %h", agg_out, pk(1, 2, 3)); end
   endtask

   // Restart from DONE: done drops at once, coo_error clears after CLEAR
   task automatic test_restart_from_done;
      int n;
      load_ring();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if ({done, busy} !== 2'b01) begin errors++; $display("FAIL restart_done got %b want 01", {done, busy}); end
      tick();
      checks++; if (coo_error !== 1'b0) begin errors++; $display("FAIL restart_err got %b want 0", coo_error); end
      n = 1;
      while (!done && n < 100) begin tick(); n++; end
      checks++; if (n !== 31) begin errors++; $display("FAIL restart_latency got %0d want 31", n); end
   endtask

   task automatic test_wrap;
      int n; bit bok;
      for (int i = 0; i < 8; i++) fm_mem[i] = '0;
      fm_mem[1] = pk(16'hFFFF, 0, 0);
      coo_mem[0] = edge_e(0, 1); coo_mem[1] = edge_e(0, 1);
      for (int i = 2; i < 6; i++) coo_mem[i] = edge_e(7, 7);
      run_main(-1, n, bok);
      checks++; if (n !== 19) begin errors++; $display("FAIL wrap_latency got %0d want 19", n); end
      agg_addr = 3'd0; #1;
      checks++; if (agg_out !== pk(16'hFFFE, 0, 0)) begin errors++; $display("FAIL wrap_agg0 got %h want %h", agg_out, pk(16'hFFFE, 0, 0)); end
   endtask

   task automatic test_start_mid_run;
      int n; bit bok;
      load_ring();
      run_main(10, n, bok);
      checks++; if (n !== 31) begin errors++; $display("FAIL midstart_latency got %0d want 31", n); end
      agg_addr = 3'd4; #1;
      checks++; if (agg_out !== pk(8, 10, 12)) begin errors++; $display("FAIL midstart_agg4 got %h want %h", agg_out, pk(8, 10, 12)); end
   endtask

   task automatic test_reset_mid_run;
      int n; bit bok;
      load_ring();
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!(en_coo && coo_address == 3'd3) && n < 100) begin tick(); n++; end
      checks++; if (n !== 16) begin errors++; $display("FAIL midrst_reach got %0d want 16", n); end
      reset = 1'b1;
      tick();
      agg_addr = 3'd0; #1;
      checks++; if ({en_coo, en_fm, busy, done, coo_error} !== 5'b0) begin errors++; $display("FAIL midrst_ctrl got %b want 00000", {en_coo, en_fm, busy, done, coo_error}); end
      checks++; if ({coo_address, fm_addr} !== 6'd0) begin errors++; $display("FAIL midrst_addr got %h want 0", {coo_address, fm_addr}); end
      checks++; if (agg_out !== 48'd0) begin errors++; $display("FAIL midrst_agg0 got %h want 0", agg_out); end
      reset = 1'b0;
      tick();
      run_main(-1, n, bok);
      checks++; if (n !== 31) begin errors++; $display("FAIL clean_latency got %0d want 31", n); end
      agg_addr = 3'd0; #1;
      checks++; if (agg_out !== pk(6, 8, 10)) begin errors++; $display("FAIL clean_agg0 got %h want %h", agg_out, pk(6, 8, 10)); end
      agg_addr = 3'd1; #1;
      checks++; if (agg_out !== pk(2, 4, 6)) begin errors++; $display("FAIL clean_agg1 got %h want %h", agg_out, pk(2, 4, 6)); end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin coo_mem[i] = '0; fm_mem[i] = '0; end
      test_reset();
      test_single_edge();
      test_ring();
      test_self_loop();
      test_invalid_edge();
      test_restart_from_done();
      test_wrap();
      test_start_mid_run();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/coo_aggregation_unit.md
Name: coo_aggregation_unit

Overview:
- Downstream stage of the feature-by-weight transformation engine.
- Starts once the FM×WM product memory is complete. Walks the graph's COO edge list and accumulates product rows into a per-node aggregation buffer: AGG = A·(FM·WM), where A is the symmetric adjacency matrix from the COO edges.
- Drives the read side of the COO memory and the FM×WM product memory.
- Exposes the finished aggregation rows through a combinational readback port for the following argmax/output stage.

Parameters:
- FEATURE_ROWS, 6, node count; rows in the FM×WM product memory.
- WEIGHT_COLS, 3, elements per product row.
- NUM_EDGES, 6, COO entries to process.
- DOT_PROD_WIDTH, 16, bit width of each product and accumulator element.
- NODE_WIDTH, $clog2(FEATURE_ROWS), node index width.
- COUNTER_EDGE_WIDTH, $clog2(NUM_EDGES), edge counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin aggregation; sampled only in IDLE and DONE.
- coo_address  out  COUNTER_EDGE_WIDTH  COO memory read address (equals edge_cnt).
- enable_read_coo  out  1  COO memory read enable.
- coo_in  in  2*NODE_WIDTH  COO entry; [NODE_WIDTH-1:0]=node_a, [2*NODE_WIDTH-1:NODE_WIDTH]=node_b. Valid 1 cycle after the address.
- read_fm_wm_addr  out  NODE_WIDTH  product memory row address.
- enable_read_fm_wm  out  1  product memory read enable.
- fm_wm_row_in  in  WEIGHT_COLS*DOT_PROD_WIDTH  product row, element j at [j*W +: W]. Valid 1 cycle after the address.
- agg_read_addr  in  NODE_WIDTH  readback row select.
- agg_row_out  out  WEIGHT_COLS*DOT_PROD_WIDTH  AGG[agg_read_addr], combinational; 0 if the address ≥ FEATURE_ROWS.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.
- coo_error  out  1  sticky; set when an edge index is out of range.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - State goes to IDLE; edge_cnt, node_a_r, node_b_r go to 0.
  - All accumulators go to 0.
  - All outputs are 0: coo_address, both read enables and read_fm_wm_addr are 0; busy, done and coo_error are 0.
  - A reset mid-operation abandons the run with no partial done.
- FSM states: IDLE, CLEAR, FETCH_COO, LATCH_COO, FETCH_B, ACC_A, ACC_B, DONE.
- IDLE: start=1 → CLEAR.
- CLEAR: zero all accumulators; edge_cnt=0; clear coo_error → FETCH_COO.
- FETCH_COO: enable_read_coo=1, coo_address=edge_cnt → LATCH_COO.
- LATCH_COO:
  - Register node_a_r and node_b_r from coo_in.
  - If either index ≥ FEATURE_ROWS: set coo_error, skip the edge, go to next-edge logic.
  - Otherwise → FETCH_B.
- FETCH_B: enable_read_fm_wm=1, read_fm_wm_addr=node_b_r → ACC_A.
- ACC_A:
  - AGG[node_a_r][j] += fm_wm_row_in[j] for all j.
  - If node_a_r==node_b_r (self-loop): added once only, go to next-edge logic.
  - Otherwise drive enable_read_fm_wm=1, read_fm_wm_addr=node_a_r → ACC_B.
- ACC_B: AGG[node_b_r][j] += fm_wm_row_in[j] for all j; then next-edge logic.
- Next-edge logic: if edge_cnt==NUM_EDGES-1 → DONE; else edge_cnt+1 → FETCH_COO.
- DONE:
  - done=1 and the accumulators hold their values.
  - start=1 → CLEAR (restart, done drops next cycle); otherwise stay in DONE.
- Arithmetic: unsigned add, each element wraps modulo 2^DOT_PROD_WIDTH. No saturation and no overflow flag.
- start is ignored while busy.
- Latency:
  - Normal edge: 5 cycles.
  - Self-loop: 4 cycles.
  - Invalid edge: 2 cycles.
  - Total (all edges normal) = 1 + 5*NUM_EDGES cycles from CLEAR entry to DONE entry. Default: 31.
- agg_row_out is valid at any time. It is guaranteed final only while done=1.
- Read enables are high only in the states listed above; addresses read 0 otherwise.

Test Plan:
- Single-edge run with NUM_EDGES=1, COO (0,2), FM_WM row0={1,2,3}, row2={4,5,6}:
  - AGG0={4,5,6}, AGG2={1,2,3}, all other rows 0.
  - done rises exactly 6 cycles after CLEAR entry.
- Default 6-edge ring (0,1),(1,2),(2,3),(3,4),(4,5),(5,0) with row i={i,i+1,i+2}:
  - AGG1={2,4,6}, AGG0={6,8,10}.
  - done after 31 cycles; busy high throughout.
- Self-loop edge (3,3) with row3={7,7,7}:
  - AGG3 gains {7,7,7} once.
  - That edge takes 4 cycles.
- Out-of-range edge (6,1) with FEATURE_ROWS=6:
  - coo_error=1 and no accumulator changes.
  - The run still reaches DONE.
  - coo_error clears on the next start.
- Wrap: two edges (0,1),(0,1) with row1={0xFFFF,0,0}:
  - AGG0[0]=0xFFFE.
- Control:
  - start pulsed mid-run → ignored.
  - reset asserted at edge 3 → all outputs 0 next cycle.
  - A new start then gives correct results from a clean buffer.
  - start in DONE restarts the run and done deasserts.
